// File: rtl/nes_bus_pkg.sv
// Shared definitions for the NES system bus: DMA state encoding,
// memory-mapped register addresses and read/write polarity.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/nes_oam_dma_if.sv
// CPU-side and system-bus-side signals of the OAM DMA arbiter.
// The master side is the environment (CPU core plus memory), and the
// slave side is the DMA controller that arbitrates the bus.
interface nes_oam_dma_if;

  logic        cpuTick;
  logic [15:0] cpuAddress;
  logic [7:0]  cpuDataOut;
  logic        cpuRw;
  logic [7:0]  busDataIn;
  logic        cpuHalt;
  logic [15:0] addressOut;
  logic [7:0]  dataOut;
  logic        rw;
  logic        dmaActive;

  modport master (
    output cpuTick, cpuAddress, cpuDataOut, cpuRw, busDataIn,
    input  cpuHalt, addressOut, dataOut, rw, dmaActive
  );

  modport slave (
    input  cpuTick, cpuAddress, cpuDataOut, cpuRw, busDataIn,
    output cpuHalt, addressOut, dataOut, rw, dmaActive
  );

endinterface

// File: rtl/nes_oam_dma.sv
// Sprite OAM DMA controller and CPU bus arbiter.
// A CPU write to $4014 freezes the CPU and copies page $XX00-$XXFF to the
// PPU OAM data port, one READ/WRITE pair per byte, then returns the bus.
module nes_oam_dma
  import nes_bus_pkg::*;
(
  input logic           clock,
  input logic           reset,
  nes_oam_dma_if.slave  bus
);

  dma_state_t  r_state;
  logic        r_parity;
  logic [7:0]  r_page;
  logic [7:0]  r_index;
  logic [7:0]  r_latch;

  logic [15:0] w_addressOut;
  logic [7:0]  w_dataOut;
  logic        w_rw;
  logic        w_trigger;

  assign w_trigger = (bus.cpuRw == RW_WRITE) && (bus.cpuAddress == OAMDMA_ADDR);

  // Control FSM and datapath registers; everything advances only on a CPU tick, except reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state  <= DMA_IDLE;
      r_parity <= 1'b0;
      r_page   <= 8'h00;
      r_index  <= 8'h00;
      r_latch  <= 8'h00;
    end else if (bus.cpuTick) begin
      r_parity <= ~r_parity;
      case (r_state)
        DMA_IDLE: begin
          if (w_trigger) begin
            r_page  <= bus.cpuDataOut;
            r_index <= 8'h00;
            r_state <= DMA_HALT;
          end
        end
        DMA_HALT: begin
          // The next tick runs with the inverted parity; READ must land on parity 0.
          if (r_parity == 1'b0) begin
            r_state <= DMA_ALIGN;
          end else begin
            r_state <= DMA_READ;
          end
        end
        DMA_ALIGN: begin
          r_state <= DMA_READ;
        end
        DMA_READ: begin
          r_latch <= bus.busDataIn;
          r_state <= DMA_WRITE;
        end
        DMA_WRITE: begin
          r_index <= r_index + 8'd1;
          if (r_index == 8'hFF) begin
            r_state <= DMA_IDLE;
          end else begin
            r_state <= DMA_READ;
          end
        end
        default: begin
          r_state <= DMA_IDLE;
        end
      endcase
    end
  end

  // Bus mux: the CPU owns the bus except while the DMA is reading or writing.
  always_comb begin
    w_addressOut = bus.cpuAddress;
    w_dataOut    = bus.cpuDataOut;
    w_rw         = bus.cpuRw;
    case (r_state)
      DMA_READ: begin
        w_addressOut = {r_page, r_index};
        w_rw         = RW_READ;
      end
      DMA_WRITE: begin
        w_addressOut = OAMDATA_ADDR;
        w_dataOut    = r_latch;
        w_rw         = RW_WRITE;
      end
      default: begin
      end
    endcase
  end

  assign bus.addressOut = w_addressOut;
  assign bus.dataOut    = w_dataOut;
  assign bus.rw         = w_rw;
  assign bus.cpuHalt    = (r_state != DMA_IDLE);
  assign bus.dmaActive  = (r_state == DMA_READ) || (r_state == DMA_WRITE);

endmodule

// File: tb/tb_nes_oam_dma.sv
// Testbench for the OAM DMA arbiter: table-driven idle vectors plus
// scoreboarded DMA runs (even/odd trigger, page wrap, reset abort).
module tb_nes_oam_dma;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rwIn;
    logic [15:0] expAddr;
    logic [7:0]  expData;
    logic        expRw;
    logic        expHalt;
  } vec_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } xfer_t;

  logic clock;
  logic reset;

  nes_oam_dma_if bus ();

  nes_oam_dma dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Memory contents: page $02 holds i ^ $A5, other pages are distinguished by the high byte.
  function automatic logic [7:0] memVal(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5 ^ 8'h02;
  endfunction

  assign bus.busDataIn = memVal(bus.addressOut);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  xfer_t       sbQueue[$];
  vec_t        vectors[6];
  int          compared;
  int          mismatched;
  int          oamWrites;
  logic        tbParity;
  logic        sHalt;
  logic        sActive;
  logic        sRw;
  logic [15:0] sAddr;
  logic [7:0]  sData;
  logic        sawRead;
  logic        firstReadParity;

  // One comparison: counts it, and reports a failure line on a difference.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Compares the sampled DMA bus cycle against the scoreboard.
  task automatic monitorCycle();
    if (sActive && sRw) begin
      if (!sawRead) begin
        sawRead         = 1'b1;
        firstReadParity = tbParity;
      end
      checkOutput("readExpected", (sbQueue.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sbQueue.size() != 0) checkOutput("readAddr", sAddr, sbQueue[0].addr);
    end else if (sActive && !sRw) begin
      checkOutput("writeAddr", sAddr, 16'h2004);
      checkOutput("writeExpected", (sbQueue.size() != 0) ? 32'd1 : 32'd0, 32'd1);
      if (sbQueue.size() != 0) begin
        xfer_t e;
        e = sbQueue.pop_front();
        checkOutput("oamData", sData, e.data);
      end
      oamWrites++;
    end
  endtask

  // One CPU cycle: drive CPU inputs, raise the tick, sample outputs before the tick edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] d, input logic r);
    @(negedge clock);
    bus.cpuTick    = 1'b0;
    bus.cpuAddress = a;
    bus.cpuDataOut = d;
    bus.cpuRw      = r;
    @(negedge clock);
    bus.cpuTick = 1'b1;
    #1;
    sHalt   = bus.cpuHalt;
    sActive = bus.dmaActive;
    sRw     = bus.rw;
    sAddr   = bus.addressOut;
    sData   = bus.dataOut;
    monitorCycle();
    @(posedge clock);
    tbParity = ~tbParity;
  endtask

  task automatic pushPage(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      xfer_t e;
      e.addr = {page, 8'(i)};
      e.data = memVal(e.addr);
      sbQueue.push_back(e);
    end
  endtask

  // Full copy: align parity, trigger, run with the CPU frozen until halt drops.
  task automatic runDma(input logic [7:0] page, input logic wantParity, input int expHalt);
    int  haltCount;
    bit  done;
    while (tbParity != wantParity) applyStimulus(16'h8000, 8'h00, 1'b1);
    applyStimulus(16'h4014, page, 1'b0);
    checkOutput("triggerPassAddr", sAddr, 16'h4014);
    checkOutput("triggerPassRw", sRw, 1'b0);
    checkOutput("triggerHalt", sHalt, 1'b0);
    pushPage(page);
    sawRead   = 1'b0;
    haltCount = 0;
    done      = 1'b0;
    for (int c = 0; c < 600 && !done; c++) begin
      applyStimulus(16'h8000, 8'h00, 1'b1);
      if (sHalt) haltCount++;
      else done = 1'b1;
    end
    checkOutput("dmaTerminated", done, 1'b1);
    checkOutput("haltCycles", haltCount, expHalt);
    checkOutput("firstReadParity", firstReadParity, 1'b0);
    checkOutput("queueDrained", sbQueue.size(), 0);
    checkOutput("passAfterDma", sAddr, 16'h8000);
    sbQueue.delete();
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    oamWrites      = 0;
    tbParity       = 1'b0;
    sawRead        = 1'b0;
    firstReadParity = 1'b0;
    reset          = 1'b1;
    bus.cpuTick    = 1'b0;
    bus.cpuAddress = 16'h0000;
    bus.cpuDataOut = 8'h00;
    bus.cpuRw      = 1'b1;

    vectors[0] = '{16'h8000, 8'h00, 1'b1, 16'h8000, 8'h00, 1'b1, 1'b0};
    vectors[1] = '{16'h0300, 8'h55, 1'b0, 16'h0300, 8'h55, 1'b0, 1'b0};
    vectors[2] = '{16'h4014, 8'h02, 1'b1, 16'h4014, 8'h02, 1'b1, 1'b0};
    vectors[3] = '{16'h4015, 8'h07, 1'b0, 16'h4015, 8'h07, 1'b0, 1'b0};
    vectors[4] = '{16'h0000, 8'h11, 1'b1, 16'h0000, 8'h11, 1'b1, 1'b0};
    vectors[5] = '{16'h1234, 8'h9A, 1'b1, 16'h1234, 8'h9A, 1'b1, 1'b0};

    // Reset with the tick pulsing, then check the idle state.
    repeat (3) begin
      @(negedge clock) bus.cpuTick = ~bus.cpuTick;
    end
    @(negedge clock);
    bus.cpuTick    = 1'b0;
    bus.cpuAddress = 16'hC0DE;
    bus.cpuDataOut = 8'h4B;
    bus.cpuRw      = 1'b0;
    #1;
    checkOutput("resetHalt", bus.cpuHalt, 1'b0);
    checkOutput("resetActive", bus.dmaActive, 1'b0);
    checkOutput("resetPassAddr", bus.addressOut, 16'hC0DE);
    checkOutput("resetPassData", bus.dataOut, 8'h4B);
    reset = 1'b0;

    // Idle passthrough and non-triggering accesses.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vectors[v].addr, vectors[v].data, vectors[v].rwIn);
      checkOutput("idleAddr", sAddr, vectors[v].expAddr);
      checkOutput("idleData", sData, vectors[v].expData);
      checkOutput("idleRw", sRw, vectors[v].expRw);
      checkOutput("idleHalt", sHalt, vectors[v].expHalt);
      checkOutput("idleActive", sActive, 1'b0);
    end

    $display("[TB] even trigger");
    runDma(8'h02, 1'b0, 513);
    $display("[TB] odd trigger");
    runDma(8'h02, 1'b1, 514);
    $display("[TB] page wrap");
    runDma(8'hFF, 1'b0, 513);

    // Abort after 100 OAM writes with a reset that arrives without a tick.
    $display("[TB] reset mid-copy");
    while (tbParity != 1'b0) applyStimulus(16'h8000, 8'h00, 1'b1);
    applyStimulus(16'h4014, 8'h03, 1'b0);
    pushPage(8'h03);
    oamWrites = 0;
    for (int c = 0; c < 400 && oamWrites < 100; c++) begin
      applyStimulus(16'h8000, 8'h00, 1'b1);
    end
    checkOutput("abortWrites", oamWrites, 100);
    @(negedge clock);
    bus.cpuTick    = 1'b0;
    reset          = 1'b1;
    bus.cpuAddress = 16'h1234;
    bus.cpuDataOut = 8'h3C;
    bus.cpuRw      = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abortHalt", bus.cpuHalt, 1'b0);
    checkOutput("abortActive", bus.dmaActive, 1'b0);
    checkOutput("abortPassAddr", bus.addressOut, 16'h1234);
    checkOutput("abortPassData", bus.dataOut, 8'h3C);
    checkOutput("abortPassRw", bus.rw, 1'b0);
    @(negedge clock);
    reset    = 1'b0;
    tbParity = 1'b0;
    sbQueue.delete();
    runDma(8'h04, 1'b0, 513);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/nes_oam_dma.md
# nes_oam_dma

Sprite-memory DMA controller and CPU bus arbiter for the NES core. A CPU write to $4014 halts the CPU and takes over the CPU bus. It copies 256 bytes from page $XX00 to the PPU OAM data port ($2004), then hands the bus back. It sits between the CPU core and the system address/data bus and muxes the bus between the two masters.

## Interface
- No parameters.
- `clock`  in  1  master clock (21.47727 MHz)
- `reset`  in  1  synchronous, active-high reset
- `cpuTick`  in  1  one-`clock` strobe marking the last master clock of each CPU cycle (÷12 enable); all state advances only when high
- `cpuAddress`  in  16  CPU address out
- `cpuDataOut`  in  8  CPU write data
- `cpuRw`  in  1  CPU read/write (1 = read, 0 = write)
- `busDataIn`  in  8  system bus read data
- `cpuHalt`  out  1  high: CPU must freeze (no state change, no bus cycle)
- `addressOut`  out  16  arbitrated bus address
- `dataOut`  out  8  arbitrated bus write data
- `rw`  out  1  arbitrated read/write
- `dmaActive`  out  1  high while the DMA owns the bus (states READ, WRITE)

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE. Transitions occur only at a `clock` edge where `cpuTick`=1.
- `parity`: 1-bit register that toggles on every `cpuTick`. Reset value is 0. "Parity of a tick" means the register value during that CPU cycle.
- Registers:
  - `page[7:0]`
  - `index[7:0]`
  - `latch[7:0]`
- IDLE:
  - Bus passes through: `addressOut`=`cpuAddress`, `dataOut`=`cpuDataOut`, `rw`=`cpuRw`.
  - On a tick with `cpuRw`=0 and `cpuAddress`=16'h4014: `page`←`cpuDataOut`, `index`←0, go to HALT.
  - The trigger write itself still passes to the bus.
  - A read of $4014 does not trigger.
- HALT: `cpuHalt`=1, bus is passthrough (CPU is frozen, so it drives a read). Next state: if parity of the next tick would be 1, go to ALIGN; otherwise go to READ.
- ALIGN: `cpuHalt`=1, passthrough, next state READ. This ensures READ always occurs on parity-0 ticks.
- READ:
  - `addressOut`={`page`,`index`}, `rw`=1.
  - At the tick, `latch`←`busDataIn`, then go to WRITE.
- WRITE:
  - `addressOut`=16'h2004, `dataOut`=`latch`, `rw`=0.
  - At the tick, `index`←`index`+1 (8-bit).
  - If `index` was 8'hFF, go to IDLE; otherwise go to READ.
- Page $FF copies $FF00–$FFFF. There is no carry into `page`.
- In IDLE, further writes to $4014 are handled as above. In any other state, `cpuAddress`/`cpuRw` are ignored.
- `reset` in any state returns to IDLE on the next `clock` edge, regardless of `cpuTick`. This releases `cpuHalt` and aborts the copy. OAM keeps whatever bytes were already written.

## Timing
- Reset values:
  - `cpuHalt`=0, `dmaActive`=0
  - state IDLE, `parity`=0, `page`=`index`=`latch`=0
  - outputs in passthrough
- Outputs are combinational from state/registers and the CPU inputs. They change only after a `clock` edge (state) or when CPU inputs change (passthrough).
- Trigger on tick T with parity p:
  - HALT occupies T+1.
  - If p=0: READ starts at T+2, giving 513 halted CPU cycles.
  - If p=1: ALIGN at T+2, READ starts at T+3, giving 514 halted CPU cycles.
- 256 READ/WRITE pairs follow, 512 CPU cycles.
- `cpuHalt` is high from the cycle after the trigger through the final WRITE, and low on the following cycle.
- `latch` is sampled at the same edge that ends READ. The bus must present data by the `cpuTick` clock.

## Structure
- Shared package `nes_bus_pkg`:
  - state enum `dma_state_t`
  - constants `OAMDMA_ADDR`=16'h4014, `OAMDATA_ADDR`=16'h2004
  - `RW_READ`=1'b1, `RW_WRITE`=1'b0
- Single module. No sub-module is needed: the parity toggle and index counter are inline registers.

## Test plan
- Idle passthrough: CPU reads $8000, then writes $55 to $0300 → `addressOut`/`dataOut`/`rw` mirror the CPU; `cpuHalt`=0.
- Even trigger: write $02 to $4014 on a parity-0 tick, with memory[$0200+i]=i^$A5 → 256 writes to $2004 with data i^$A5 in order; reads at $0200..$02FF; `cpuHalt` high for exactly 513 ticks.
- Odd trigger: same write on a parity-1 tick → one ALIGN cycle; `cpuHalt` high for 514 ticks; first READ on a parity-0 tick.
- No false trigger: CPU read of $4014, and a write to $4015 → state stays IDLE; `cpuHalt` never asserts.
- Page wrap: write $FF to $4014 → reads $FF00..$FFFF, terminates after `index` $FF; no access to $0000.
- Reset mid-copy: assert `reset` after 100 WRITE cycles → next edge is IDLE, `cpuHalt`=0, passthrough; a new $4014 write restarts at `index` 0.
